// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, presents it to a combinational-read
// instruction memory and latches the returned word into the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 2048,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] im_a,
    output logic        im_r,
    input  logic [31:0] im_rd,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        out_of_range;
    logic        fetch_fault;

    assign pc_plus4     = pc_q + 32'd4;
    assign misaligned   = |pc_q[1:0];
    assign out_of_range = {2'b00, pc_q[31:2]} >= IMEM_LIMIT;
    assign fetch_fault  = misaligned || out_of_range;

    // The PC is always visible on the bus; only RUN actually requests a read.
    assign im_a = pc_q;
    assign im_r = (state_q == RUN);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        id_pc_d  = id_pc_q;
        id_pc4_d = id_pc4_q;
        valid_d  = valid_q;
        err_d    = err_q;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                // A bad PC wins over everything: the word on im_rd is never trusted.
                if (fetch_fault) begin
                    state_d = HALT;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                end else if (redirect) begin
                    pc_d    = redirect_pc;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d     = pc_plus4;
                    instr_d  = im_rd;
                    id_pc_d  = pc_q;
                    id_pc4_d = pc_plus4;
                    valid_d  = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
                err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            id_pc_q  <= 32'd0;
            id_pc4_q <= 32'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            id_pc_q  <= id_pc_d;
            id_pc4_q <= id_pc4_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign id_instr  = instr_q;
    assign id_pc     = id_pc_q;
    assign id_pc4    = id_pc4_q;
    assign id_valid  = valid_q;
    assign fetch_err = err_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 2048, the instruction memory depth in words.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0000, the instruction value inserted on bubbles.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-007 SHALL have port redirect  input  1  branch/jump taken; load redirect_pc and flush.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port im_a  output  32  byte address to instruction memory.
REQ-010 SHALL have port im_r  output  1  instruction memory read enable.
REQ-011 SHALL have port im_rd  input  32  instruction word from memory, combinational in im_a/im_r.
REQ-012 SHALL have port id_instr  output  32  IF/ID latched instruction.
REQ-013 SHALL have port id_pc  output  32  IF/ID latched PC of id_instr.
REQ-014 SHALL have port id_pc4  output  32  id_pc + 4.
REQ-015 SHALL have port id_valid  output  1  id_instr is a real fetched instruction.
REQ-016 SHALL have port fetch_err  output  1  sticky fault: misaligned or out-of-range fetch.

Function
REQ-017 SHALL implement FSM states BOOT, RUN, HALT; reset enters BOOT.
REQ-018 BOOT SHALL last exactly one cycle, with im_r=0 and pc=RESET_PC, then go to RUN unconditionally.
REQ-019 In RUN, im_a SHALL equal pc and im_r SHALL be 1, combinationally.
REQ-020 In BOOT and HALT, im_r SHALL be 0 and im_a SHALL equal pc.
REQ-021 In RUN, update priority per edge SHALL be: redirect > stall > normal advance.
REQ-022 Normal advance SHALL load pc<=pc+4 (modulo 2^32), id_instr<=im_rd, id_pc<=pc, id_pc4<=pc+4, id_valid<=1.
REQ-023 Stall (no redirect) SHALL hold pc, id_instr, id_pc, id_pc4 and id_valid unchanged.
REQ-024 Redirect SHALL load pc<=redirect_pc, id_instr<=NOP_INSTR, id_valid<=0, with id_pc/id_pc4 held; this applies even when stall=1.
REQ-025 Redirect in BOOT SHALL be ignored; redirect in HALT SHALL be ignored.
REQ-026 Fetch latency SHALL be 1 cycle: the instruction at pc appears on id_instr the edge after pc is presented.
REQ-027 The first id_valid=1 SHALL occur at the second rising edge after rst_n is sampled high.
REQ-028 When in RUN and pc[1:0]!=0 or pc[31:2]>=IMEM_WORDS, the FSM SHALL go to HALT next edge without latching im_rd, set id_valid<=0, id_instr<=NOP_INSTR and fetch_err<=1.
REQ-029 The HALT check SHALL take priority over redirect and stall.
REQ-030 HALT SHALL be exited only by reset; fetch_err SHALL remain 1 until reset.
REQ-031 Address arithmetic SHALL be 32-bit unsigned; pc+4 at 32'hFFFF_FFFC SHALL wrap to 0, which is caught as out-of-range only if IMEM_WORDS bounds apply.

Reset
REQ-032 When rst_n=0 at an edge, the block SHALL set state=BOOT, pc=RESET_PC, id_instr=NOP_INSTR, id_pc=0, id_pc4=0, id_valid=0, fetch_err=0, regardless of stall, redirect or current state.
REQ-033 Reset asserted mid-stall or mid-redirect SHALL override both with no residual effect.

Verification
REQ-034 Reset then release with memory words 0..3 = A0,A1,A2,A3 -> one cycle with im_r=0, then id_instr A0,A1,A2 on consecutive edges, id_pc 0,4,8, id_pc4 4,8,12, id_valid=1.
REQ-035 stall=1 for 3 cycles after id_instr=A1 -> id_instr/id_pc hold A1/4 and im_a holds 8 for 3 cycles, then A2 resumes.
REQ-036 redirect=1 with redirect_pc=32'h40 while stall=1 -> next edge id_valid=0, id_instr=NOP_INSTR, im_a=32'h40; following edge id_instr=mem[16], id_pc=32'h40.
REQ-037 redirect_pc=32'h42 -> one cycle later HALT, fetch_err=1, im_r=0, id_valid=0; stays so under further redirects until rst_n=0.
REQ-038 Sequential fetch reaching pc=IMEM_WORDS*4 (32'h2000) -> HALT with fetch_err=1, last valid id_pc=32'h1FFC.
REQ-039 rst_n=0 for one cycle while in HALT -> all outputs return to REQ-032 values and REQ-034 sequence repeats.
